// File: rtl/wt_cache_pkg.sv
// Shared types, widths and helpers for the direct-mapped write-through cache.
package wt_cache_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    localparam int BE_W      = 2;
    // Wide enough for the smallest legal cache (2 lines); narrower tags are zero-extended.
    localparam int TAG_MAX_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [DATA_W-1:0]    data;
    } line_t;

    function automatic logic [TAG_MAX_W-1:0] tag_of(input logic [ADDR_W-1:0] addr,
                                                    input int               idx_w);
        return TAG_MAX_W'(addr >> (idx_w + 1));
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_d,
                                                      input logic [DATA_W-1:0] new_d,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_d[8*b +: 8];
            end else begin
                r[8*b +: 8] = old_d[8*b +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wt_cache_if.sv
// CPU-side and memory-side request/response bundle; slave = cache view, master = environment view.
interface wt_cache_if;
    import wt_cache_pkg::*;

    logic              cpu_read;
    logic              cpu_write;
    logic [BE_W-1:0]   cpu_byte_enable;
    logic [ADDR_W-1:0] cpu_address;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_resp;
    logic [DATA_W-1:0] cpu_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [BE_W-1:0]   pmem_byte_enable;
    logic [ADDR_W-1:0] pmem_address;
    logic [DATA_W-1:0] pmem_wdata;
    logic              pmem_resp;
    logic [DATA_W-1:0] pmem_rdata;

    modport slave (
        input  cpu_read, cpu_write, cpu_byte_enable, cpu_address, cpu_wdata,
        input  pmem_resp, pmem_rdata,
        output cpu_resp, cpu_rdata,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_byte_enable, cpu_address, cpu_wdata,
        output pmem_resp, pmem_rdata,
        input  cpu_resp, cpu_rdata,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/wt_cache_array.sv
// Valid/tag/data storage with combinational lookup, full-line fill and byte-lane merge.
module wt_cache_array
    import wt_cache_pkg::*;
#(
    parameter  int NUM_LINES = 8,
    localparam int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [TAG_MAX_W-1:0] tag_i,
    input  logic                 fill_i,
    input  logic [DATA_W-1:0]    fill_data_i,
    input  logic                 merge_i,
    input  logic [BE_W-1:0]      be_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic                 hit_o,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_MAX_W-1:0] tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES];
    line_t                line_s;

    // Lookup of the addressed line.
    always_comb begin
        line_s  = '{valid: valid_q[idx_i], tag: tag_q[idx_i], data: data_q[idx_i]};
        hit_o   = line_s.valid && (line_s.tag == tag_i);
        rdata_o = line_s.data;
    end

    // Valid bits are the only state that needs clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // Tag/data update: whole line on fill, selected byte lanes on a write hit.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= fill_data_i;
        end else if (merge_i) begin
            data_q[idx_i] <= merge_bytes(data_q[idx_i], wdata_i, be_i);
        end
    end

endmodule

// File: rtl/wt_cache.sv
// Direct-mapped write-through, no-write-allocate cache: FSM and port muxing around the line array.
module wt_cache
    import wt_cache_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    wt_cache_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LINES);

    state_e            state_q;
    logic              cpu_resp_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              pmem_read_q;
    logic              pmem_write_q;
    logic [BE_W-1:0]   pmem_be_q;
    logic [ADDR_W-1:0] pmem_addr_q;
    logic [DATA_W-1:0] pmem_wdata_q;

    logic [IDX_W-1:0]     idx_s;
    logic [TAG_MAX_W-1:0] tag_s;
    logic                 hit_s;
    logic [DATA_W-1:0]    line_data_s;
    logic                 fill_s;
    logic                 merge_s;

    // Address split and array write strobes on memory completion.
    always_comb begin
        idx_s   = bus.cpu_address[IDX_W:1];
        tag_s   = tag_of(bus.cpu_address, IDX_W);
        fill_s  = 1'b0;
        merge_s = 1'b0;
        if (bus.pmem_resp) begin
            fill_s  = (state_q == FILL);
            merge_s = (state_q == WRITE) && hit_s;
        end else begin
            fill_s  = 1'b0;
            merge_s = 1'b0;
        end
    end

    wt_cache_array #(.NUM_LINES(NUM_LINES)) u_array (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_i       (idx_s),
        .tag_i       (tag_s),
        .fill_i      (fill_s),
        .fill_data_i (bus.pmem_rdata),
        .merge_i     (merge_s),
        .be_i        (bus.cpu_byte_enable),
        .wdata_i     (bus.cpu_wdata),
        .hit_o       (hit_s),
        .rdata_o     (line_data_s)
    );

    // Control FSM; every port output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cpu_resp_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_be_q    <= 2'b00;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        state_q      <= WRITE;
                        pmem_write_q <= 1'b1;
                        pmem_addr_q  <= bus.cpu_address;
                        pmem_wdata_q <= bus.cpu_wdata;
                        pmem_be_q    <= bus.cpu_byte_enable;
                    end else if (bus.cpu_read && hit_s) begin
                        state_q     <= RESP;
                        cpu_rdata_q <= line_data_s;
                        cpu_resp_q  <= 1'b1;
                    end else if (bus.cpu_read) begin
                        state_q     <= FILL;
                        pmem_read_q <= 1'b1;
                        pmem_addr_q <= {bus.cpu_address[ADDR_W-1:1], 1'b0};
                        pmem_be_q   <= 2'b11;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state_q     <= RESP;
                        pmem_read_q <= 1'b0;
                        cpu_rdata_q <= bus.pmem_rdata;
                        cpu_resp_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.pmem_resp) begin
                        state_q      <= RESP;
                        pmem_write_q <= 1'b0;
                        cpu_resp_q   <= 1'b1;
                    end
                end
                RESP: begin
                    // The CPU still holds its request this cycle; returning to IDLE skips it.
                    state_q    <= IDLE;
                    cpu_resp_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    cpu_resp_q   <= 1'b0;
                    pmem_read_q  <= 1'b0;
                    pmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_resp         = cpu_resp_q;
    assign bus.cpu_rdata        = cpu_rdata_q;
    assign bus.pmem_read        = pmem_read_q;
    assign bus.pmem_write       = pmem_write_q;
    assign bus.pmem_byte_enable = pmem_be_q;
    assign bus.pmem_address     = pmem_addr_q;
    assign bus.pmem_wdata       = pmem_wdata_q;

endmodule
